// File: rtl/dmp_domain_tracker.sv
// -----------------------------------------------------------------------------
// dmp_domain_tracker
//
// Tracks the current JIT memory-protection domain beside commit. The block
// consumes committed chdom/retdom instructions, keeps a LIFO of return
// domains, checks every chdom against a from->to permission matrix, and
// forces a dedicated domain while a trap is being serviced.
//
// Ports:
//   clk_i             clock
//   rst_ni            synchronous active-low reset
//   flush_i           context switch: back to ResetDom, stack emptied, RUN
//   trap_i            trap entry pulse
//   trap_ret_i        trap return pulse
//   commit_valid_i    committed instruction valid
//   commit_chg_dom_i  committed instruction is a domain change
//   commit_is_ret_i   1 = retdom, 0 = chdom
//   commit_target_i   chdom target domain
//   curdom_o          current domain (registered)
//   depth_o           return-stack occupancy
//   empty_o           depth_o == 0
//   full_o            depth_o == StackDepth
//   in_trap_o         tracker is in trap mode
//   fault_o           one-cycle fault pulse
//   fault_cause_o     0 illegal, 1 overflow, 2 underflow, 3 change in trap;
//                     holds its value until the next fault
// -----------------------------------------------------------------------------
module dmp_domain_tracker #(
   parameter int NrDomains  = 4,
   parameter int StackDepth = 4,
   parameter logic [NrDomains*NrDomains-1:0] TransAllow = 16'h0842,
   parameter int ResetDom   = 0,
   parameter int TrapDom    = 0,
   localparam int DomW      = (NrDomains > 1) ? $clog2(NrDomains) : 1,
   localparam int DepW      = $clog2(StackDepth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            trap_i,
   input  logic            trap_ret_i,
   input  logic            commit_valid_i,
   input  logic            commit_chg_dom_i,
   input  logic            commit_is_ret_i,
   input  logic [DomW-1:0] commit_target_i,
   output logic [DomW-1:0] curdom_o,
   output logic [DepW-1:0] depth_o,
   output logic            empty_o,
   output logic            full_o,
   output logic            in_trap_o,
   output logic            fault_o,
   output logic [1:0]      fault_cause_o
);

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } state_t;

   localparam logic [1:0] CauseIllegal   = 2'd0;
   localparam logic [1:0] CauseOverflow  = 2'd1;
   localparam logic [1:0] CauseUnderflow = 2'd2;
   localparam logic [1:0] CauseInTrap    = 2'd3;

   state_t          state_reg,  state_next;
   logic [DomW-1:0] curdom_reg, curdom_next;
   logic [DomW-1:0] saved_reg,  saved_next;
   logic [DepW-1:0] depth_reg,  depth_next;
   logic            empty_reg,  full_reg;
   logic            fault_reg,  fault_next;
   logic [1:0]      cause_reg,  cause_next;
   logic            push;

   logic [DomW-1:0] entry_q [StackDepth];
   logic [DomW-1:0] top;
   logic            allowed;
   logic            is_full;
   logic            is_chg;

   // Return stack: one register per slot, written only on a push into the
   // slot addressed by the current depth. Slots are never cleared; the
   // depth counter alone defines what is live.
   for (genvar gi = 0; gi < StackDepth; gi++) begin : g_stack
      logic [DomW-1:0] entry_reg;
      always_ff @(posedge clk_i) begin
         if (push && depth_reg == DepW'(gi)) begin
            entry_reg <= curdom_reg;
         end
      end
      assign entry_q[gi] = entry_reg;
   end

   // Top-of-stack lookup, written as a compare loop so that no index wider
   // than the stack ever reaches the array.
   always_comb begin
      top = DomW'(ResetDom);
      for (int i = 0; i < StackDepth; i++) begin
         if (depth_reg == DepW'(i + 1)) begin
            top = entry_q[i];
         end
      end
   end

   // Permission lookup. A target code with no matching domain (only possible
   // when NrDomains is not a power of two) finds no entry and stays disallowed.
   always_comb begin
      allowed = 1'b0;
      for (int f = 0; f < NrDomains; f++) begin
         for (int t = 0; t < NrDomains; t++) begin
            if (curdom_reg == DomW'(f) && commit_target_i == DomW'(t)) begin
               allowed = TransAllow[f*NrDomains + t];
            end
         end
      end
   end

   assign is_full = (depth_reg == DepW'(StackDepth));
   assign is_chg  = commit_valid_i & commit_chg_dom_i;

   // Next-state logic. The highest-priority asserted event owns the cycle,
   // even when it is a no-op in the current state (trap_i while in TRAP,
   // trap_ret_i while in RUN); everything below it is dropped.
   always_comb begin
      state_next  = state_reg;
      curdom_next = curdom_reg;
      saved_next  = saved_reg;
      depth_next  = depth_reg;
      fault_next  = 1'b0;
      cause_next  = cause_reg;
      push        = 1'b0;

      if (flush_i) begin
         state_next  = RUN;
         curdom_next = DomW'(ResetDom);
         depth_next  = '0;
      end else if (trap_i) begin
         if (state_reg == RUN) begin
            saved_next  = curdom_reg;
            curdom_next = DomW'(TrapDom);
            state_next  = TRAP;
         end
      end else if (trap_ret_i) begin
         if (state_reg == TRAP) begin
            curdom_next = saved_reg;
            state_next  = RUN;
         end
      end else if (is_chg) begin
         if (state_reg == TRAP) begin
            fault_next = 1'b1;
            cause_next = CauseInTrap;
         end else if (commit_is_ret_i) begin
            if (depth_reg == '0) begin
               fault_next = 1'b1;
               cause_next = CauseUnderflow;
            end else begin
               curdom_next = top;
               depth_next  = depth_reg - 1'b1;
            end
         end else if (!allowed) begin
            fault_next = 1'b1;
            cause_next = CauseIllegal;
         end else if (is_full) begin
            fault_next = 1'b1;
            cause_next = CauseOverflow;
         end else begin
            push        = 1'b1;
            curdom_next = commit_target_i;
            depth_next  = depth_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg  <= RUN;
         curdom_reg <= DomW'(ResetDom);
         saved_reg  <= DomW'(ResetDom);
         depth_reg  <= '0;
         empty_reg  <= 1'b1;
         full_reg   <= 1'b0;
         fault_reg  <= 1'b0;
         cause_reg  <= 2'd0;
      end else begin
         state_reg  <= state_next;
         curdom_reg <= curdom_next;
         saved_reg  <= saved_next;
         depth_reg  <= depth_next;
         empty_reg  <= (depth_next == '0);
         full_reg   <= (depth_next == DepW'(StackDepth));
         fault_reg  <= fault_next;
         cause_reg  <= cause_next;
      end
   end

   assign curdom_o      = curdom_reg;
   assign depth_o       = depth_reg;
   assign empty_o       = empty_reg;
   assign full_o        = full_reg;
   assign in_trap_o     = (state_reg == TRAP);
   assign fault_o       = fault_reg;
   assign fault_cause_o = cause_reg;

endmodule
